// File: rtl/mig_ui_responder_if.sv
// -----------------------------------------------------------------------------
// mig_ui_responder_if
// Bundle of the MIG-style app_* user-interface signals between a traffic
// generator (master) and the BRAM-backed responder (slave).
//
// Handshake semantics (applies to every channel in this bundle):
//   A transfer happens on a rising clock edge when its valid and its ready are
//   both high in the cycle before that edge. The command channel pairs
//   app_en with app_rdy. The write-data channel pairs app_wdf_wren and
//   app_wdf_end with app_wdf_rdy. The master holds payload and valid steady
//   until the transfer happens. Read data (app_rd_data_valid) has no ready
//   signal; the master must take it in the cycle it is presented.
//   Maintenance requests are single-cycle pulses, and each one is answered by
//   a single-cycle ack.
//
// Signals:
//   app_addr[26:0], app_cmd[2:0], app_en    command channel (master -> slave)
//   app_rdy                                 command ready  (slave -> master)
//   app_wdf_data[127:0], app_wdf_mask[15:0],
//   app_wdf_wren, app_wdf_end               write-data channel (master -> slave)
//   app_wdf_rdy                             write-data ready (slave -> master)
//   app_rd_data[127:0], app_rd_data_valid,
//   app_rd_data_end                         read return (slave -> master)
//   app_sr_req, app_ref_req, app_zq_req     maintenance requests
//   app_sr_active, app_ref_ack, app_zq_ack  maintenance status/acks
//   init_calib_complete                     calibration done (sticky)
// -----------------------------------------------------------------------------
interface mig_ui_responder_if;
  logic [26:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy;
  logic [127:0] app_wdf_data;
  logic [15:0]  app_wdf_mask;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic         app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         app_rd_data_end;
  logic         app_sr_req;
  logic         app_ref_req;
  logic         app_zq_req;
  logic         app_sr_active;
  logic         app_ref_ack;
  logic         app_zq_ack;
  logic         init_calib_complete;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask,
           app_wdf_wren, app_wdf_end, app_sr_req, app_ref_req, app_zq_req,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
           app_rd_data_end, app_sr_active, app_ref_ack, app_zq_ack,
           init_calib_complete
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask,
           app_wdf_wren, app_wdf_end, app_sr_req, app_ref_req, app_zq_req,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
           app_rd_data_end, app_sr_active, app_ref_ack, app_zq_ack,
           init_calib_complete
  );
endinterface

// File: rtl/mig_ui_responder.sv
// -----------------------------------------------------------------------------
// mig_ui_responder
// Synthesizable stand-in for the MIG DDR3 user interface. It answers the app_*
// protocol from an on-chip array of 128-bit phrases. Read data comes back a
// fixed RD_LATENCY cycles after a read command is accepted. The block also
// models the calibration delay after reset, optional periodic backpressure on
// app_rdy and app_wdf_rdy, and single-cycle refresh/ZQ acks.
//
// Ports:
//   clk_in       UI clock
//   rst_in       asynchronous, active-high reset (memory contents survive it)
//   ui           mig_ui_responder_if.slave; all app_* signals
//   dbg_state_o  {calibration state, write-pairing state} for observation
// -----------------------------------------------------------------------------
module mig_ui_responder #(
  parameter int DEPTH        = 4096,
  parameter int ADDR_SHIFT   = 7,
  parameter int RD_LATENCY   = 4,
  parameter int CALIB_CYCLES = 64,
  parameter int STALL_PERIOD = 0
) (
  input  logic              clk_in,
  input  logic              rst_in,
  mig_ui_responder_if.slave ui,
  output logic [2:0]        dbg_state_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CAL_W = (CALIB_CYCLES > 1) ? $clog2(CALIB_CYCLES) : 1;
  localparam int STL_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
  // Pipeline stage that feeds the registered memory read (one before the last)
  localparam int FEED  = (RD_LATENCY > 1) ? RD_LATENCY - 2 : 0;

  typedef enum logic { CAL_WAIT = 1'b0, CAL_DONE = 1'b1 } cal_state_t;
  typedef enum logic [1:0] {
    PR_EMPTY = 2'd0,  // nothing held
    PR_CMD   = 2'd1,  // write command waiting for its data beat
    PR_DATA  = 2'd2   // data beat waiting for its write command
  } pair_state_t;

  cal_state_t  cal_q, cal_d;
  pair_state_t pair_q, pair_d;

  logic [CAL_W-1:0] cal_cnt_q, cal_cnt_d;
  logic [STL_W-1:0] stall_cnt_q;
  logic             ref_ack_q, zq_ack_q;

  logic [IDX_W-1:0] hold_idx_q;
  logic [127:0]     hold_data_q;
  logic [15:0]      hold_mask_q;

  logic [RD_LATENCY-1:0] pipe_vld_q;
  logic [IDX_W-1:0]      pipe_idx_q [RD_LATENCY];
  logic [127:0]          rd_data_q;

  logic [127:0] mem [DEPTH];

  logic             calibrated, cal_last;
  logic             stall_cmd, stall_wdf, ack_cycle;
  logic             app_rdy, app_wdf_rdy;
  logic             cmd_acc, wr_acc, rd_acc, dat_acc;
  logic [IDX_W-1:0] cmd_idx;
  logic             load_cmd, load_data, commit_en;
  logic [IDX_W-1:0] commit_idx;
  logic [127:0]     commit_data;
  logic [15:0]      commit_mask;
  logic             feed_vld;
  logic [IDX_W-1:0] feed_idx;
  logic             unused_sr;

  // ---------------------------------------------------------------------------
  // Ready gating and acceptance
  // ---------------------------------------------------------------------------
  assign calibrated = (cal_q == CAL_DONE);
  assign stall_cmd  = (STALL_PERIOD != 0) && (stall_cnt_q == '0);
  assign stall_wdf  = (STALL_PERIOD != 0) && (stall_cnt_q == STL_W'(STALL_PERIOD / 2));
  assign ack_cycle  = ref_ack_q | zq_ack_q;

  // Reads are refused while a write command is held. A read can therefore
  // never overtake a write it follows.
  assign app_rdy     = calibrated & (pair_q != PR_CMD) & ~stall_cmd & ~ack_cycle;
  assign app_wdf_rdy = calibrated & (pair_q != PR_DATA) & ~stall_wdf;

  assign cmd_acc = ui.app_en & app_rdy;
  assign wr_acc  = cmd_acc & (ui.app_cmd == 3'b000);
  assign rd_acc  = cmd_acc & (ui.app_cmd == 3'b001);
  assign dat_acc = ui.app_wdf_wren & ui.app_wdf_end & app_wdf_rdy;

  // Out-of-range addresses wrap silently.
  assign cmd_idx = IDX_W'((32'(ui.app_addr) >> ADDR_SHIFT) % DEPTH);

  // ---------------------------------------------------------------------------
  // Calibration FSM
  // ---------------------------------------------------------------------------
  assign cal_last = (CALIB_CYCLES <= 1) || (cal_cnt_q == CAL_W'(CALIB_CYCLES - 1));

  always_comb begin
    cal_d     = cal_q;
    cal_cnt_d = cal_cnt_q;
    case (cal_q)
      CAL_WAIT: begin
        if (cal_last) cal_d = CAL_DONE;
        else          cal_cnt_d = cal_cnt_q + 1'b1;
      end
      CAL_DONE: cal_d = CAL_DONE;
      default:  cal_d = CAL_WAIT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write-pairing FSM: a command and a data beat may arrive in either order.
  // Whichever arrives first waits in a single-entry hold.
  // ---------------------------------------------------------------------------
  always_comb begin
    pair_d      = pair_q;
    load_cmd    = 1'b0;
    load_data   = 1'b0;
    commit_en   = 1'b0;
    commit_idx  = cmd_idx;
    commit_data = ui.app_wdf_data;
    commit_mask = ui.app_wdf_mask;
    case (pair_q)
      PR_EMPTY: begin
        if (wr_acc && dat_acc) begin
          commit_en = 1'b1;
        end else if (wr_acc) begin
          load_cmd = 1'b1;
          pair_d   = PR_CMD;
        end else if (dat_acc) begin
          load_data = 1'b1;
          pair_d    = PR_DATA;
        end
      end
      PR_CMD: begin
        if (dat_acc) begin
          commit_en  = 1'b1;
          commit_idx = hold_idx_q;
          pair_d     = PR_EMPTY;
        end
      end
      PR_DATA: begin
        if (wr_acc) begin
          commit_en   = 1'b1;
          commit_data = hold_data_q;
          commit_mask = hold_mask_q;
          pair_d      = PR_EMPTY;
        end
      end
      default: pair_d = PR_EMPTY;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read pipeline: the memory is read one stage before the last, so the data
  // register and the valid flag become visible together.
  // ---------------------------------------------------------------------------
  assign feed_vld = (RD_LATENCY == 1) ? rd_acc  : pipe_vld_q[FEED];
  assign feed_idx = (RD_LATENCY == 1) ? cmd_idx : pipe_idx_q[FEED];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cal_q       <= CAL_WAIT;
      cal_cnt_q   <= '0;
      pair_q      <= PR_EMPTY;
      stall_cnt_q <= '0;
      ref_ack_q   <= 1'b0;
      zq_ack_q    <= 1'b0;
      hold_idx_q  <= '0;
      hold_data_q <= '0;
      hold_mask_q <= '0;
      pipe_vld_q  <= '0;
      for (int s = 0; s < RD_LATENCY; s++) pipe_idx_q[s] <= '0;
      rd_data_q   <= '0;
    end else begin
      cal_q     <= cal_d;
      cal_cnt_q <= cal_cnt_d;
      pair_q    <= pair_d;
      if (STALL_PERIOD > 1) begin
        stall_cnt_q <= (stall_cnt_q == STL_W'(STALL_PERIOD - 1)) ? '0 : stall_cnt_q + 1'b1;
      end
      // A request held high still produces only a single-cycle ack.
      ref_ack_q <= ui.app_ref_req & ~ref_ack_q;
      zq_ack_q  <= ui.app_zq_req & ~zq_ack_q;
      if (load_cmd) hold_idx_q <= cmd_idx;
      if (load_data) begin
        hold_data_q <= ui.app_wdf_data;
        hold_mask_q <= ui.app_wdf_mask;
      end
      pipe_vld_q[0] <= rd_acc;
      pipe_idx_q[0] <= cmd_idx;
      for (int s = 1; s < RD_LATENCY; s++) begin
        pipe_vld_q[s] <= pipe_vld_q[s-1];
        pipe_idx_q[s] <= pipe_idx_q[s-1];
      end
      if (feed_vld) rd_data_q <= mem[feed_idx];
    end
  end

  // Storage is deliberately not reset, so its contents survive a reset.
  always_ff @(posedge clk_in) begin
    if (commit_en) begin
      for (int b = 0; b < 16; b++) begin
        if (!commit_mask[b]) mem[commit_idx][b*8 +: 8] <= commit_data[b*8 +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ui.app_rdy             = app_rdy;
  assign ui.app_wdf_rdy         = app_wdf_rdy;
  assign ui.app_rd_data         = rd_data_q;
  assign ui.app_rd_data_valid   = pipe_vld_q[RD_LATENCY-1];
  assign ui.app_rd_data_end     = pipe_vld_q[RD_LATENCY-1];
  assign ui.app_sr_active       = 1'b0;
  assign ui.app_ref_ack         = ref_ack_q;
  assign ui.app_zq_ack          = zq_ack_q;
  assign ui.init_calib_complete = calibrated;
  assign dbg_state_o            = {cal_q, pair_q};

  // Self-refresh requests are not modelled.
  assign unused_sr = ui.app_sr_req;

endmodule

// File: tb/tb_mig_ui_responder.sv
`timescale 1ns/1ps
module tb_mig_ui_responder;

  localparam int L   = 4;
  localparam int CAL = 64;

  // --------------------------- clock / reset ---------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // --------------------------- DUTs ------------------------------------------
  mig_ui_responder_if ui0();
  mig_ui_responder_if ui1();
  logic [2:0] dbg0, dbg1;

  mig_ui_responder #(.CALIB_CYCLES(CAL)) dut0 (
    .clk_in(clk), .rst_in(rst), .ui(ui0.slave), .dbg_state_o(dbg0));
  mig_ui_responder #(.CALIB_CYCLES(8), .STALL_PERIOD(4)) dut1 (
    .clk_in(clk), .rst_in(rst), .ui(ui1.slave), .dbg_state_o(dbg1));

  // Shared drive signals. sel picks which DUT sees the handshakes.
  int           sel    = 0;
  logic [26:0]  d_addr = '0;
  logic [2:0]   d_cmd  = '0;
  logic         d_en   = 1'b0;
  logic [127:0] d_data = '0;
  logic [15:0]  d_mask = '0;
  logic         d_wren = 1'b0;
  logic         d_ref  = 1'b0;
  logic         d_zq   = 1'b0;
  logic         d_sr   = 1'b0;

  assign ui0.app_addr = d_addr;  assign ui1.app_addr = d_addr;
  assign ui0.app_cmd  = d_cmd;   assign ui1.app_cmd  = d_cmd;
  assign ui0.app_en   = d_en & (sel == 0);
  assign ui1.app_en   = d_en & (sel == 1);
  assign ui0.app_wdf_data = d_data;  assign ui1.app_wdf_data = d_data;
  assign ui0.app_wdf_mask = d_mask;  assign ui1.app_wdf_mask = d_mask;
  assign ui0.app_wdf_wren = d_wren & (sel == 0);
  assign ui1.app_wdf_wren = d_wren & (sel == 1);
  assign ui0.app_wdf_end  = d_wren & (sel == 0);
  assign ui1.app_wdf_end  = d_wren & (sel == 1);
  assign ui0.app_ref_req = d_ref;  assign ui1.app_ref_req = d_ref;
  assign ui0.app_zq_req  = d_zq;   assign ui1.app_zq_req  = d_zq;
  assign ui0.app_sr_req  = d_sr;   assign ui1.app_sr_req  = d_sr;

  logic cur_rdy, cur_wdf;
  assign cur_rdy = (sel == 0) ? ui0.app_rdy     : ui1.app_rdy;
  assign cur_wdf = (sel == 0) ? ui0.app_wdf_rdy : ui1.app_wdf_rdy;

  // --------------------------- scoreboard ------------------------------------
  int n_cmp = 0;
  int n_err = 0;
  logic [159:0] exp_q[$];  // {due cycle, expected read data}

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mon(input logic [127:0] data, input logic dend, input string nm);
    logic [159:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_unexpected: got read data %h, want no read return", nm, data);
    end else begin
      e = exp_q.pop_front();
      check({nm, "_data"}, data, e[127:0]);
      check({nm, "_cycle"}, 128'(cyc), 128'(e[159:128]));
      check({nm, "_end"}, 128'(dend), 128'(1));
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ui0.app_rd_data_valid) mon(ui0.app_rd_data, ui0.app_rd_data_end, "rd0");
      if (ui1.app_rd_data_valid) mon(ui1.app_rd_data, ui1.app_rd_data_end, "rd1");
    end
  end

  // --------------------------- driver tasks ----------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command; for reads the expected data is queued on acceptance.
  task automatic send_cmd(input logic [2:0] c, input logic [26:0] a, input logic [127:0] exp_rd);
    int n = 0;
    bit acc = 1'b0;
    d_cmd = c; d_addr = a; d_en = 1'b1;
    while (!acc && n < 40) begin
      @(negedge clk);
      acc = cur_rdy;
      if (acc && c == 3'b001) exp_q.push_back({32'(cyc + L), exp_rd});
      step();
      n++;
    end
    d_en = 1'b0;
    if (!acc) begin
      n_cmp++; n_err++;
      $display("FAIL cmd_accept: got no acceptance of cmd %0d addr %h in %0d cycles, want acceptance", c, a, n);
    end
  endtask

  task automatic send_data(input logic [127:0] d, input logic [15:0] m);
    int n = 0;
    bit acc = 1'b0;
    d_data = d; d_mask = m; d_wren = 1'b1;
    while (!acc && n < 40) begin
      @(negedge clk);
      acc = cur_wdf;
      step();
      n++;
    end
    d_wren = 1'b0;
    if (!acc) begin
      n_cmp++; n_err++;
      $display("FAIL data_accept: got no acceptance of data in %0d cycles, want acceptance", n);
    end
  endtask

  // Command and data offered together; each is dropped once it is taken.
  task automatic do_write(input logic [26:0] a, input logic [127:0] d, input logic [15:0] m);
    int n = 0;
    bit c_ok = 1'b0, w_ok = 1'b0, cn, wn;
    d_cmd = 3'b000; d_addr = a; d_en = 1'b1;
    d_data = d; d_mask = m; d_wren = 1'b1;
    while (!(c_ok && w_ok) && n < 40) begin
      @(negedge clk);
      cn = d_en && cur_rdy;
      wn = d_wren && cur_wdf;
      step();
      n++;
      if (cn) begin c_ok = 1'b1; d_en = 1'b0; end
      if (wn) begin w_ok = 1'b1; d_wren = 1'b0; end
    end
    d_en = 1'b0; d_wren = 1'b0;
    if (!(c_ok && w_ok)) begin
      n_cmp++; n_err++;
      $display("FAIL write_accept: got cmd=%0b data=%0b accepted, want both", c_ok, w_ok);
    end
  endtask

  // --------------------------- watchdog --------------------------------------
  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running at %0t, want finish", $time);
    $fatal(1, "watchdog expired");
  end

  // --------------------------- test ------------------------------------------
  typedef struct {
    bit           wr;
    logic [26:0]  addr;
    logic [127:0] data;   // write data, or expected read data
    logic [15:0]  mask;
  } vec_t;

  initial begin
    vec_t tbl[9];
    logic [127:0] rnd[8];
    int t0, rl, wl, fr, fw;

    tbl[0] = '{1'b1, 27'(5 << 7),           {16{8'hA5}}, 16'h0000};
    tbl[1] = '{1'b0, 27'(5 << 7),           {16{8'hA5}}, 16'h0000};
    tbl[2] = '{1'b1, 27'(6 << 7),           128'h0123456789ABCDEF_FEDCBA9876543210, 16'h0000};
    tbl[3] = '{1'b1, 27'(6 << 7),           {16{8'hFF}}, 16'hFF00};
    tbl[4] = '{1'b0, 27'(6 << 7),           128'h0123456789ABCDEF_FFFFFFFFFFFFFFFF, 16'h0000};
    tbl[5] = '{1'b1, 27'((4096 + 7) << 7),  {16{8'h77}}, 16'h0000};
    tbl[6] = '{1'b0, 27'(7 << 7),           {16{8'h77}}, 16'h0000};
    tbl[7] = '{1'b0, 27'((7 << 7) + 5),     {16{8'h77}}, 16'h0000};
    tbl[8] = '{1'b0, 27'(5 << 7),           {16{8'hA5}}, 16'h0000};

    // Reset state
    repeat (3) step();
    check("reset_flags", {ui0.init_calib_complete, ui0.app_rdy, ui0.app_wdf_rdy,
          ui0.app_rd_data_valid, ui0.app_rd_data_end, ui0.app_ref_ack,
          ui0.app_zq_ack, ui0.app_sr_active}, 8'h00);
    check("reset_rd_data", ui0.app_rd_data, 128'h0);

    // Calibration and ready gating
    rst = 1'b0;
    for (int k = 1; k <= CAL + 4; k++) begin
      step();
      check("calib_gate", {ui0.init_calib_complete, ui0.app_rdy, ui0.app_wdf_rdy},
            (k >= CAL) ? 3'b111 : 3'b000);
    end

    // Table-driven writes and reads
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].wr) begin
        do_write(tbl[i].addr, tbl[i].data, tbl[i].mask);
        check("write_no_hold", {ui0.app_rdy, ui0.app_wdf_rdy}, 2'b11);
      end else begin
        send_cmd(3'b001, tbl[i].addr, tbl[i].data);
      end
    end
    repeat (L + 2) step();

    // Command arrives first, data two cycles later, byte 0 masked
    do_write(27'(40 << 7), {16{8'h11}}, 16'h0000);
    send_cmd(3'b000, 27'(40 << 7), 128'h0);
    check("cmdfirst_rdy_held", ui0.app_rdy, 1'b0);
    step();
    check("cmdfirst_rdy_held2", {ui0.app_rdy, ui0.app_wdf_rdy}, 2'b01);
    send_data({16{8'h22}}, 16'h0001);
    check("cmdfirst_rdy_back", ui0.app_rdy, 1'b1);
    send_cmd(3'b001, 27'(40 << 7), {{15{8'h22}}, 8'h11});

    // Data arrives first; a second beat is refused while the first is held
    send_data({16{8'h33}}, 16'h0000);
    check("datafirst_wdf_held", {ui0.app_wdf_rdy, ui0.app_rdy}, 2'b01);
    d_data = {16{8'h44}}; d_mask = 16'h0000; d_wren = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("datafirst_second_blocked", cur_wdf, 1'b0);
      step();
    end
    send_cmd(3'b000, 27'(41 << 7), 128'h0);
    send_data({16{8'h44}}, 16'h0000);
    send_cmd(3'b000, 27'(42 << 7), 128'h0);
    send_cmd(3'b001, 27'(41 << 7), {16{8'h33}});
    send_cmd(3'b001, 27'(42 << 7), {16{8'h44}});
    repeat (L + 2) step();

    // Eight back-to-back reads
    for (int i = 0; i < 8; i++) do_write(27'((16 + i) << 7), {4{32'hC0DE_0000 | i}}, 16'h0000);
    t0 = cyc;
    for (int i = 0; i < 8; i++) send_cmd(3'b001, 27'((16 + i) << 7), {4{32'hC0DE_0000 | i}});
    check("b2b_issue_cycles", 128'(cyc - t0), 128'(8));
    repeat (L + 2) step();

    // Maintenance acks
    d_ref = 1'b1;
    check("ref_req_cycle", {ui0.app_ref_ack, ui0.app_rdy}, 2'b01);
    step(); d_ref = 1'b0;
    check("ref_ack", {ui0.app_ref_ack, ui0.app_zq_ack, ui0.app_rdy}, 3'b100);
    step();
    check("ref_ack_end", {ui0.app_ref_ack, ui0.app_zq_ack, ui0.app_rdy}, 3'b001);
    d_ref = 1'b1; d_zq = 1'b1;
    step(); d_ref = 1'b0; d_zq = 1'b0;
    check("refzq_ack", {ui0.app_ref_ack, ui0.app_zq_ack, ui0.app_rdy}, 3'b110);
    step();
    check("refzq_ack_end", {ui0.app_ref_ack, ui0.app_zq_ack, ui0.app_rdy}, 3'b001);
    d_sr = 1'b1;
    step(); d_sr = 1'b0;
    check("sr_ignored", {ui0.app_ref_ack, ui0.app_zq_ack, ui0.app_rdy, ui0.app_sr_active}, 4'b0010);

    // Periodic backpressure on the second instance
    sel = 1;
    rl = 0; wl = 0; fr = -1; fw = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!ui1.app_rdy)     begin rl++; if (fr < 0) fr = i; end
      if (!ui1.app_wdf_rdy) begin wl++; if (fw < 0) fw = i; end
      step();
    end
    check("stall_rdy_lows", 128'(rl), 128'(2));
    check("stall_wdf_lows", 128'(wl), 128'(2));
    check("stall_offset", 128'((fw - fr + 4) % 4), 128'(2));
    for (int i = 0; i < 8; i++) begin
      rnd[i] = {$urandom, $urandom, $urandom, $urandom};
      do_write(27'(i << 7), rnd[i], 16'h0000);
      repeat ($urandom_range(0, 2)) step();
    end
    for (int i = 0; i < 8; i++) send_cmd(3'b001, 27'(i << 7), rnd[i]);
    repeat (L + 3) step();
    check("stall_sb_drained", 128'(exp_q.size()), 128'(0));

    // Asynchronous reset with reads in flight
    sel = 0;
    send_cmd(3'b001, 27'(5 << 7), {16{8'hA5}});
    send_cmd(3'b001, 27'(7 << 7), {16{8'h77}});
    #3;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("midreset_outputs", {ui0.init_calib_complete, ui0.app_rdy, ui0.app_rd_data_valid}, 3'b000);
    step(); step();
    rst = 1'b0;
    repeat (CAL) step();
    check("recalib", ui0.init_calib_complete, 1'b1);
    send_cmd(3'b001, 27'(5 << 7), {16{8'hA5}});
    send_cmd(3'b001, 27'(7 << 7), {16{8'h77}});
    repeat (L + 3) step();

    check("sb_drained", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
